// File: rtl/esm_issue_scheduler.sv
// -----------------------------------------------------------------------------
// esm_issue_scheduler
//
// Owns the occupancy of the bs-entry instruction buffer that sits behind the
// ESM dependency-tracking core. Hands out the lowest free slot to dispatch.
// Each cycle it picks one dependency-free WAITING slot, in round-robin order,
// and places it in a valid/ready issue register. A slot is freed again when
// its completion is reported.
//
// Ports
//   clk              system clock, rising edge
//   rst              asynchronous active-high reset
//   alloc_valid      dispatch requests a buffer slot
//   alloc_ready      a FREE slot exists
//   alloc_index      lowest-numbered FREE slot (ESM core buffer_index)
//   ready_positions  per-slot dependency-free flags from the ESM core
//   issue_valid      issue register holds an entry
//   issue_index      slot being issued
//   issue_ready      execution side accepts the issue
//   complete_valid   an issued slot finished execution
//   complete_index   slot finishing
//   occupancy        number of non-FREE slots
//   full / empty     occupancy == bs / occupancy == 0
//   err              sticky illegal-completion flag
// -----------------------------------------------------------------------------
module esm_issue_scheduler #(
  parameter int bs = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_valid,
  output logic                  alloc_ready,
  output logic [$clog2(bs)-1:0] alloc_index,
  input  logic [bs-1:0]         ready_positions,
  output logic                  issue_valid,
  output logic [$clog2(bs)-1:0] issue_index,
  input  logic                  issue_ready,
  input  logic                  complete_valid,
  input  logic [$clog2(bs)-1:0] complete_index,
  output logic [$clog2(bs):0]   occupancy,
  output logic                  full,
  output logic                  empty,
  output logic                  err
);

  localparam int IW = $clog2(bs);

  typedef enum logic [1:0] {
    SLOT_FREE    = 2'd0,
    SLOT_WAITING = 2'd1,
    SLOT_ISSUED  = 2'd2
  } slot_state_e;

  slot_state_e   r_state [bs];
  logic [IW-1:0] r_rr_ptr;
  logic [IW-1:0] r_issue_index;
  logic          r_issue_valid;
  logic          r_err;
  logic [IW:0]   r_occupancy;

  logic          w_alloc_ready;
  logic [IW-1:0] w_alloc_index;
  logic          w_alloc_fire;
  logic [bs-1:0] w_cand;
  logic          w_found;
  logic [IW-1:0] w_pick;
  logic          w_load;
  logic          w_cmp_held;
  logic          w_cmp_legal;
  logic          w_cmp_illegal;

  // Lowest-numbered FREE slot: scan downward so the smallest index wins.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_alloc_ready = 1'b0;
    w_alloc_index = '0;
    for (int i = bs - 1; i >= 0; i--) begin
      if (r_state[i] == SLOT_FREE) begin
        w_alloc_ready = 1'b1;
        w_alloc_index = IW'(i);
      end
    end
  end

  assign w_alloc_fire = alloc_valid & w_alloc_ready;

  // Only WAITING slots are eligible; ready bits of FREE/ISSUED slots are masked.
  always_comb begin
    for (int i = 0; i < bs; i++) begin
      w_cand[i] = (r_state[i] == SLOT_WAITING) & ready_positions[i];
    end
  end

  // Round-robin pick starting at rr_ptr. The offset wraps naturally in IW bits
  // because bs is a power of two. The scan runs downward so the smallest offset wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = bs - 1; k >= 0; k--) begin
      if (w_cand[r_rr_ptr + IW'(k)]) begin
        w_found = 1'b1;
        w_pick  = r_rr_ptr + IW'(k);
      end
    end
  end

  // The register can reload on the handshake edge, so back-to-back issue has no bubble.
  assign w_load = ~r_issue_valid | issue_ready;

  // A slot still sitting in the issue register cannot have executed yet.
  assign w_cmp_held    = r_issue_valid & (complete_index == r_issue_index);
  assign w_cmp_legal   = complete_valid & (r_state[complete_index] == SLOT_ISSUED) & ~w_cmp_held;
  assign w_cmp_illegal = complete_valid & ~w_cmp_legal;

  // Alloc (FREE), pick (WAITING) and legal complete (ISSUED) always touch
  // disjoint slots, so the per-slot writes below never collide.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the slot-state array is reset explicitly because FREE-after-reset is functional state, not just storage.
      for (int i = 0; i < bs; i++) begin
        r_state[i] <= SLOT_FREE;
      end
      r_rr_ptr      <= '0;
      r_issue_index <= '0;
      r_issue_valid <= 1'b0;
      r_err         <= 1'b0;
      r_occupancy   <= '0;
    end else begin
      if (w_alloc_fire) begin
        r_state[w_alloc_index] <= SLOT_WAITING;
      end
      if (w_cmp_legal) begin
        r_state[complete_index] <= SLOT_FREE;
      end
      if (w_load) begin
        if (w_found) begin
          r_state[w_pick] <= SLOT_ISSUED;
          r_issue_index   <= w_pick;
          r_issue_valid   <= 1'b1;
          r_rr_ptr        <= w_pick + 1'b1;
        end else begin
          r_issue_valid <= 1'b0;
        end
      end
      if (w_cmp_illegal) begin
        r_err <= 1'b1;
      end
      // Cannot wrap: alloc needs a FREE slot and a legal complete needs an ISSUED one.
      r_occupancy <= r_occupancy + (IW+1)'(w_alloc_fire) - (IW+1)'(w_cmp_legal);
    end
  end

  assign alloc_ready = w_alloc_ready;
  assign alloc_index = w_alloc_index;
  assign issue_valid = r_issue_valid;
  assign issue_index = r_issue_index;
  assign occupancy   = r_occupancy;
  assign full        = (r_occupancy == (IW+1)'(bs));
  assign empty       = (r_occupancy == '0);
  assign err         = r_err;

endmodule

// File: tb/tb_esm_issue_scheduler.sv
// -----------------------------------------------------------------------------
// tb_esm_issue_scheduler
//
// Directed self-checking bench for esm_issue_scheduler (bs = 16).
// Inputs change 1 ns after a rising edge. Outputs are checked in that same
// window, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_esm_issue_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid;
  logic        alloc_ready;
  logic [3:0]  alloc_index;
  logic [15:0] ready_positions;
  logic        issue_valid;
  logic [3:0]  issue_index;
  logic        issue_ready;
  logic        complete_valid;
  logic [3:0]  complete_index;
  logic [4:0]  occupancy;
  logic        full;
  logic        empty;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  esm_issue_scheduler #(.bs(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .alloc_valid     (alloc_valid),
    .alloc_ready     (alloc_ready),
    .alloc_index     (alloc_index),
    .ready_positions (ready_positions),
    .issue_valid     (issue_valid),
    .issue_index     (issue_index),
    .issue_ready     (issue_ready),
    .complete_valid  (complete_valid),
    .complete_index  (complete_index),
    .occupancy       (occupancy),
    .full            (full),
    .empty           (empty),
    .err             (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst             = 1'b1;
    alloc_valid     = 1'b0;
    ready_positions = '0;
    issue_ready     = 1'b0;
    complete_valid  = 1'b0;
    complete_index  = '0;
    do_reset();

    // ---------------- reset state ----------------
    check("rst_issue_valid", 32'(issue_valid), 0);
    check("rst_issue_index", 32'(issue_index), 0);
    check("rst_occupancy",   32'(occupancy),   0);
    check("rst_empty",       32'(empty),       1);
    check("rst_full",        32'(full),        0);
    check("rst_err",         32'(err),         0);
    check("rst_alloc_ready", 32'(alloc_ready), 1);
    check("rst_alloc_index", 32'(alloc_index), 0);

    // ---------------- fill ----------------
    alloc_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("fill_idx_%0d", i), 32'(alloc_index), 32'(i));
      tick();
    end
    check("fill_full",        32'(full),        1);
    check("fill_alloc_ready", 32'(alloc_ready), 0);
    check("fill_occupancy",   32'(occupancy),   16);
    check("fill_empty",       32'(empty),       0);
    tick();  // 17th request, must be ignored
    check("fill_17th_occ", 32'(occupancy), 16);
    alloc_valid = 1'b0;

    // ---------------- complete/alloc overlap on full buffer ----------------
    ready_positions = 16'h0010;
    issue_ready     = 1'b0;
    tick();
    check("ovl_issue_valid", 32'(issue_valid), 1);
    check("ovl_issue_index", 32'(issue_index), 4);
    ready_positions = '0;
    issue_ready     = 1'b1;
    tick();  // handshake; no further candidates
    check("ovl_drained", 32'(issue_valid), 0);
    complete_valid = 1'b1;
    complete_index = 4'd4;
    alloc_valid    = 1'b1;
    check("ovl_alloc_ready_same", 32'(alloc_ready), 0);
    tick();
    complete_valid = 1'b0;
    alloc_valid    = 1'b0;
    check("ovl_alloc_ready_next", 32'(alloc_ready), 1);
    check("ovl_alloc_index_next", 32'(alloc_index), 4);
    check("ovl_occupancy",        32'(occupancy),   15);
    check("ovl_err",              32'(err),         0);

    // ---------------- illegal completion of a WAITING slot ----------------
    complete_valid = 1'b1;
    complete_index = 4'd9;
    tick();
    complete_valid = 1'b0;
    check("ill_err",       32'(err),       1);
    check("ill_occupancy", 32'(occupancy), 15);
    ready_positions = 16'h0200;  // slot 9 must still be WAITING
    tick();
    check("ill_slot9_issue_v", 32'(issue_valid), 1);
    check("ill_slot9_issue_i", 32'(issue_index), 9);
    ready_positions = '0;
    tick();
    check("ill_err_sticky", 32'(err), 1);
    complete_valid = 1'b1;
    complete_index = 4'd9;
    tick();
    complete_valid = 1'b0;
    check("ill_legal_occ", 32'(occupancy), 14);
    rst = 1'b1;
    #1;
    check("ill_err_cleared_async", 32'(err),       0);
    check("ill_occ_cleared_async", 32'(occupancy), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // ---------------- single issue ----------------
    alloc_valid = 1'b1;
    repeat (4) tick();
    alloc_valid     = 1'b0;
    ready_positions = 16'h0004;
    issue_ready     = 1'b1;
    check("si_before", 32'(issue_valid), 0);
    tick();
    check("si_valid_n1", 32'(issue_valid), 1);
    check("si_index_n1", 32'(issue_index), 2);
    tick();
    check("si_valid_n2", 32'(issue_valid), 0);
    check("si_occ",      32'(occupancy),   4);
    ready_positions = '0;
    do_reset();

    // ---------------- round-robin ----------------
    alloc_valid = 1'b1;
    repeat (8) tick();
    alloc_valid     = 1'b0;
    ready_positions = 16'h00FF;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("rr_valid_%0d", i), 32'(issue_valid), 1);
      check($sformatf("rr_index_%0d", i), 32'(issue_index), 32'(i));
    end
    tick();
    check("rr_drained", 32'(issue_valid), 0);
    ready_positions = '0;
    complete_valid  = 1'b1;
    complete_index  = 4'd0;
    tick();
    complete_index = 4'd5;
    tick();
    complete_valid = 1'b0;
    check("rr_occ_after_cmp", 32'(occupancy), 6);
    alloc_valid = 1'b1;
    check("rr_refill_idx0", 32'(alloc_index), 0);
    tick();
    check("rr_refill_idx5", 32'(alloc_index), 5);
    tick();
    alloc_valid     = 1'b0;
    ready_positions = 16'h0021;
    tick();
    check("rr_wrap_first",  32'(issue_index), 0);
    tick();
    check("rr_wrap_second", 32'(issue_index), 5);
    tick();
    check("rr_wrap_done",   32'(issue_valid), 0);
    ready_positions = '0;
    do_reset();

    // ---------------- backpressure ----------------
    alloc_valid = 1'b1;
    repeat (6) tick();
    alloc_valid     = 1'b0;
    ready_positions = 16'h0008;
    issue_ready     = 1'b0;
    tick();
    check("bp_load_idx", 32'(issue_index), 3);
    ready_positions = 16'h0038;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("bp_hold_v_%0d", i), 32'(issue_valid), 1);
      check($sformatf("bp_hold_i_%0d", i), 32'(issue_index), 3);
    end
    // Completing the slot still held in the issue register is illegal.
    complete_valid = 1'b1;
    complete_index = 4'd3;
    tick();
    complete_valid = 1'b0;
    check("bp_held_cmp_err", 32'(err),         1);
    check("bp_held_cmp_occ", 32'(occupancy),   6);
    check("bp_held_cmp_idx", 32'(issue_index), 3);
    issue_ready = 1'b1;
    tick();
    check("bp_release_v", 32'(issue_valid), 1);
    check("bp_release_i", 32'(issue_index), 4);
    tick();
    check("bp_next_i", 32'(issue_index), 5);
    tick();
    check("bp_done", 32'(issue_valid), 0);

    // ---------------- reset in the middle of a handshake ----------------
    ready_positions = 16'h0001;
    issue_ready     = 1'b0;
    tick();
    check("mid_load_v", 32'(issue_valid), 1);
    check("mid_load_i", 32'(issue_index), 0);
    rst = 1'b1;
    #1;
    check("mid_rst_v",   32'(issue_valid), 0);
    check("mid_rst_err", 32'(err),         0);
    check("mid_rst_emp", 32'(empty),       1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ready_positions = '0;
    tick();
    check("mid_after_v", 32'(issue_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/esm_issue_scheduler.md
Name: esm_issue_scheduler

Overview:
- Downstream consumer of the ESM dependency-tracking core's `ready_positions` bitmap.
- Owns occupancy of the bs-entry instruction buffer: hands out free `buffer_index` values to the dispatch side, then selects one dependency-free waiting entry per cycle for issue.
- Selection is round-robin; issue uses a valid/ready handshake.
- Frees an entry when its completion is reported.

Parameters:
- bs, 16, number of buffer entries; must equal the ESM core's bs; power of two, ≥2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- alloc_valid  input  1  dispatch requests a buffer slot this cycle.
- alloc_ready  output  1  a free slot exists (combinational from registered state).
- alloc_index  output  $clog2(bs)  lowest-numbered FREE slot; drives the ESM core's `buffer_index`; valid when alloc_ready=1.
- ready_positions  input  bs  per-slot dependency-free flags from the ESM core.
- issue_valid  output  1  issue register holds an entry.
- issue_index  output  $clog2(bs)  slot being issued.
- issue_ready  input  1  execution side accepts.
- complete_valid  input  1  an issued slot finished execution.
- complete_index  input  $clog2(bs)  slot finishing.
- occupancy  output  $clog2(bs)+1  number of non-FREE slots.
- full  output  1  occupancy == bs.
- empty  output  1  occupancy == 0.
- err  output  1  sticky illegal-completion flag.

Behaviour:
- Per-slot 2-bit state: FREE, WAITING, ISSUED.
- Reset (async, immediate):
  - all slots FREE; rr_ptr=0; issue_valid=0; issue_index=0; occupancy=0; empty=1; full=0; err=0.
  - A reset mid-handshake drops the pending issue.
- Allocation:
  - alloc_fire = alloc_valid & alloc_ready.
  - On fire, slot alloc_index goes FREE→WAITING at the next edge.
  - alloc_ready=0 when all slots are non-FREE; alloc_valid is then ignored.
- Candidate vector = WAITING[i] & ready_positions[i].
  - A slot allocated at edge N is a candidate from cycle N onward, provided ready_positions is set.
- Issue register:
  - Loadable when issue_valid=0, or when issue_valid=1 & issue_ready=1 (back-to-back issue, no bubble).
  - On load: picks the first candidate scanning rr_ptr, rr_ptr+1, … modulo bs.
  - On load: sets issue_index, sets issue_valid=1, moves that slot WAITING→ISSUED, and sets rr_ptr = picked index+1 mod bs.
  - If no candidate exists: issue_valid←0, or stays 0.
- Latency: candidate present at cycle N → issue_valid=1 at cycle N+1.
- Hold rule: while issue_valid=1 & issue_ready=0, issue_index is stable and candidates are not consumed.
- Completion:
  - complete_valid with slot in ISSUED → slot goes FREE at the next edge.
  - Completion of a FREE or WAITING slot → ignored and err←1 (sticky until reset).
  - Completion of the slot currently held in the issue register (issue_valid=1, not yet handshaken) is also illegal → err←1; the slot is unchanged.
- Simultaneous events:
  - Alloc and complete in the same cycle: both take effect. alloc_index comes from pre-edge state, so a slot being freed this cycle is not reallocated until the next cycle.
  - Alloc and issue-load in the same cycle target different slots by construction: the FREE vs WAITING states are disjoint.
- Occupancy:
  - Next occupancy = occupancy + alloc_fire − legal_complete_fire.
  - Never wraps; full and empty are derived combinationally from the occupancy register.
- ready_positions bits for FREE or ISSUED slots are ignored.

Test Plan:
- Reset then fill:
  - Stimulus: rst pulse, then 16 consecutive alloc_valid cycles.
  - Response: alloc_index 0..15 in order; full=1 and alloc_ready=0 after the 16th; a 17th request is ignored with occupancy=16.
- Single issue:
  - Stimulus: alloc slots 0–3; ready_positions=16'h0004 at cycle N; issue_ready=1.
  - Response: issue_valid=1, issue_index=2 at N+1; slot 2 ISSUED; issue_valid=0 at N+2.
- Round-robin:
  - Stimulus: slots 0–7 WAITING; ready_positions=16'h00FF; issue_ready held 1.
  - Response: issue_index sequence 0,1,2,…,7 on consecutive cycles; rr_ptr=8 after.
  - Stimulus: refill slots 0 and 5 ready.
  - Response: order 0 then 5 (wrap from 8).
- Backpressure:
  - Stimulus: issue_ready=0 for 5 cycles with slot 3 issued.
  - Response: issue_index stays 3 and issue_valid=1 throughout; other ready slots remain WAITING.
  - Stimulus: release issue_ready.
  - Response: next candidate is loaded the same edge as the handshake.
- Complete/alloc overlap:
  - Stimulus: full buffer; slot 4 ISSUED; complete_index=4 alongside alloc_valid=1.
  - Response: alloc_ready=0 that cycle; next cycle alloc_ready=1, alloc_index=4, occupancy=15.
- Illegal completion:
  - Stimulus: complete_valid with index 9 while slot 9 is WAITING.
  - Response: err=1 next cycle and stays 1; slot 9 still WAITING; occupancy unchanged.
  - Stimulus: rst.
  - Response: err=0.
